// File: rtl/app_stream_rx.sv
// Application descriptor stream parser: tags every received flit with its
// field kind and task index, and queues it in a 2-entry output FIFO.
module app_stream_rx #(
  parameter int FLIT_SIZE = 32,
  parameter int MAX_TASKS = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 credit_o,
  input  logic                 eoa_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [FLIT_SIZE-1:0] out_data_o,
  output logic [3:0]           out_kind_o,
  output logic [7:0]           out_task_o,
  output logic                 out_last_o,
  output logic                 app_done_o,
  output logic                 err_o,
  output logic                 done_o
);

  typedef enum logic [3:0] {
    S_DSIZE = 4'd0, S_TCNT = 4'd1, S_MAP  = 4'd2, S_TAG   = 4'd3, S_GRAPH = 4'd4,
    S_TEXT  = 4'd5, S_DATA = 4'd6, S_BSS  = 4'd7, S_ENTRY = 4'd8, S_BIN   = 4'd9
  } state_t;

  typedef struct packed {
    logic [FLIT_SIZE-1:0] data;
    logic [3:0]           kind;
    logic [7:0]           tsk;
    logic                 last;
  } ent_t;

  state_t               r_state;
  logic [FLIT_SIZE-1:0] r_dsize, r_cnt, r_text, r_data;
  logic [7:0]           r_tcnt, r_idx;
  ent_t                 r_fifo [2];
  logic [1:0]           r_count;
  logic                 r_credit, r_app_done, r_err, r_done;

  state_t               w_next;
  logic                 w_push, w_pop, w_last, w_task_end, w_more, w_tcnt_big;
  logic [7:0]           w_task, w_tcnt_in;
  logic [8:0]           w_idx_inc;
  logic [FLIT_SIZE:0]   w_bin_sum;
  logic [FLIT_SIZE-1:0] w_bin_words;
  logic [1:0]           w_count_nxt;
  ent_t                 w_ent;

  assign w_push      = rx_i & r_credit;
  assign w_pop       = (r_count != 2'd0) & out_ready_i;
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_idx_inc   = {1'b0, r_idx} + 9'd1;
  assign w_more      = w_idx_inc < {1'b0, r_tcnt};
  assign w_tcnt_big  = data_i > FLIT_SIZE'(MAX_TASKS);
  assign w_tcnt_in   = w_tcnt_big ? 8'(MAX_TASKS) : data_i[7:0];
  // Sum kept one bit wider so text+data cannot wrap before the word shift.
  assign w_bin_sum   = {1'b0, r_text} + {1'b0, r_data};
  assign w_bin_words = FLIT_SIZE'(w_bin_sum >> 2);

  always_comb begin
    w_next     = r_state;
    w_last     = 1'b0;
    w_task_end = 1'b0;
    w_task     = 8'd0;
    case (r_state)
      S_DSIZE: w_next = S_TCNT;
      S_TCNT: begin
        if (w_tcnt_in != 8'd0)      w_next = S_MAP;
        else if (r_dsize != '0)     w_next = S_GRAPH;
        else begin w_next = S_DSIZE; w_last = 1'b1; end
      end
      S_MAP: begin w_next = S_TAG; w_task = r_idx; end
      S_TAG: begin
        w_task = r_idx;
        if (w_more)                 w_next = S_MAP;
        else if (r_dsize != '0)     w_next = S_GRAPH;
        else                        w_next = S_TEXT;
      end
      S_GRAPH: begin
        if (r_cnt == r_dsize - FLIT_SIZE'(1)) begin
          if (r_tcnt != 8'd0) w_next = S_TEXT;
          else begin w_next = S_DSIZE; w_last = 1'b1; end
        end
      end
      S_TEXT: begin w_next = S_DATA;  w_task = r_idx; end
      S_DATA: begin w_next = S_BSS;   w_task = r_idx; end
      S_BSS:  begin w_next = S_ENTRY; w_task = r_idx; end
      S_ENTRY: begin
        w_task = r_idx;
        if (w_bin_words != '0) w_next = S_BIN;
        else                   w_task_end = 1'b1;
      end
      S_BIN: begin
        w_task = r_idx;
        if (r_cnt == w_bin_words - FLIT_SIZE'(1)) w_task_end = 1'b1;
      end
      default: w_next = S_DSIZE;
    endcase
    if (w_task_end) begin
      if (w_more) w_next = S_TEXT;
      else begin w_next = S_DSIZE; w_last = 1'b1; end
    end
  end

  always_comb begin
    w_ent      = '0;
    w_ent.data = data_i;
    w_ent.kind = r_state;
    w_ent.tsk  = w_task;
    w_ent.last = w_last;
  end

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      r_state    <= S_DSIZE;
      r_dsize    <= '0;
      r_cnt      <= '0;
      r_text     <= '0;
      r_data     <= '0;
      r_tcnt     <= 8'd0;
      r_idx      <= 8'd0;
      r_app_done <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (eoa_i && r_state != S_DSIZE) r_err <= 1'b1;
      r_app_done <= w_push & w_last;
      if (w_push) begin
        r_state <= w_next;
        case (r_state)
          S_DSIZE: r_dsize <= data_i;
          S_TCNT: begin
            r_tcnt <= w_tcnt_in;
            r_idx  <= 8'd0;
            r_cnt  <= '0;
            if (w_tcnt_big) r_err <= 1'b1;
          end
          S_TAG: begin
            if (data_i != FLIT_SIZE'(1)) r_err <= 1'b1;
            r_idx <= w_more ? w_idx_inc[7:0] : 8'd0;
          end
          S_GRAPH: r_cnt  <= (w_next == S_GRAPH) ? r_cnt + FLIT_SIZE'(1) : '0;
          S_TEXT:  r_text <= data_i;
          S_DATA:  r_data <= data_i;
          S_ENTRY: r_cnt  <= '0;
          S_BIN:   r_cnt  <= (w_next == S_BIN) ? r_cnt + FLIT_SIZE'(1) : '0;
          default: ;
        endcase
        if (w_task_end) r_idx <= w_more ? w_idx_inc[7:0] : 8'd0;
      end
    end
  end

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_count   <= 2'd0;
      r_credit  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_credit <= w_count_nxt < 2'd2;
      r_done   <= eoa_i && ((w_push ? w_next : r_state) == S_DSIZE) && (w_count_nxt == 2'd0);
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_fifo[0] <= w_ent;
          else                 r_fifo[1] <= w_ent;
        end
        2'b01: r_fifo[0] <= r_fifo[1];
        2'b11: begin
          if (r_count == 2'd1) r_fifo[0] <= w_ent;
          else begin
            r_fifo[0] <= r_fifo[1];
            r_fifo[1] <= w_ent;
          end
        end
        default: ;
      endcase
    end
  end

  assign credit_o    = r_credit;
  assign out_valid_o = r_count != 2'd0;
  assign out_data_o  = r_fifo[0].data;
  assign out_kind_o  = r_fifo[0].kind;
  assign out_task_o  = r_fifo[0].tsk;
  assign out_last_o  = r_fifo[0].last;
  assign app_done_o  = r_app_done;
  assign err_o       = r_err;
  assign done_o      = r_done;

endmodule

// File: tb/tb_app_stream_rx.sv
// Randomized scoreboard bench: applications are expanded into expected tagged
// flits from the field layout; a monitor pops and compares on each transfer.
module tb_app_stream_rx;
  localparam int FW = 32;

  logic          clk_i = 1'b0, rst_ni = 1'b1, rx_i = 1'b0, eoa_i = 1'b0, out_ready_i = 1'b0;
  logic [FW-1:0] data_i = '0;
  logic          credit_o, out_valid_o, out_last_o, app_done_o, err_o, done_o;
  logic [FW-1:0] out_data_o;
  logic [3:0]    out_kind_o;
  logic [7:0]    out_task_o;

  app_stream_rx #(.FLIT_SIZE(FW), .MAX_TASKS(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i), .data_i(data_i), .credit_o(credit_o),
    .eoa_i(eoa_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_kind_o(out_kind_o), .out_task_o(out_task_o),
    .out_last_o(out_last_o), .app_done_o(app_done_o), .err_o(err_o), .done_o(done_o));

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [FW-1:0] d;
    logic [3:0]    k;
    logic [7:0]    t;
    logic          l;
  } exp_t;

  exp_t          exp_q[$];
  logic [FW-1:0] stim[$];
  int total = 0, bad = 0, exp_apps = 0, n_done = 0, n_flit = 0, ready_mode = 1;
  bit exp_err = 1'b0;

  function automatic exp_t mk(input logic [FW-1:0] d, input int k, input int t);
    exp_t e;
    e.d = d; e.k = 4'(k); e.t = 8'(t); e.l = 1'b0;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expand one application into its flit sequence straight from the field layout.
  task automatic gen_app(input int dsize, input int tcnt, input int tagv, input int txt, input int dat);
    exp_t a[$];
    exp_t e;
    int nt, tx, dt;
    nt = (tcnt > 32) ? 32 : tcnt;
    if (tcnt > 32 || (nt > 0 && tagv != 1)) exp_err = 1'b1;
    a.push_back(mk(FW'(dsize), 0, 0));
    a.push_back(mk(FW'(tcnt), 1, 0));
    for (int i = 0; i < nt; i++) begin
      a.push_back(mk($urandom, 2, i));
      a.push_back(mk(FW'(tagv), 3, i));
    end
    for (int g = 0; g < dsize; g++) a.push_back(mk($urandom, 4, 0));
    for (int t = 0; t < nt; t++) begin
      tx = (txt < 0) ? $urandom_range(0, 15) : txt;
      dt = (dat < 0) ? $urandom_range(0, 15) : dat;
      a.push_back(mk(FW'(tx), 5, t));
      a.push_back(mk(FW'(dt), 6, t));
      a.push_back(mk($urandom, 7, t));
      a.push_back(mk($urandom, 8, t));
      for (int b = 0; b < (tx + dt) / 4; b++) a.push_back(mk($urandom, 9, t));
    end
    e = a.pop_back();
    e.l = 1'b1;
    a.push_back(e);
    foreach (a[i]) begin
      stim.push_back(a[i].d);
      exp_q.push_back(a[i]);
    end
    exp_apps++;
  endtask

  // Upstream driver with random idle cycles.
  initial begin
    bit acc;
    acc = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (acc && stim.size() > 0) void'(stim.pop_front());
      if (!rst_ni && stim.size() > 0) begin
        rx_i   = ($urandom_range(0, 3) != 0);
        data_i = stim[0];
      end else rx_i = 1'b0;
      @(negedge clk_i);
      acc = rx_i && credit_o;
    end
  end

  initial begin
    forever begin
      @(posedge clk_i); #1;
      case (ready_mode)
        0:       out_ready_i = 1'b0;
        1:       out_ready_i = 1'b1;
        default: out_ready_i = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: scoreboard compare on each transfer, stall stability, done pulses.
  initial begin
    exp_t e;
    logic [63:0] h;
    bit stall;
    stall = 1'b0;
    h = '0;
    forever begin
      @(negedge clk_i);
      if (rst_ni) stall = 1'b0;
      else begin
        if (app_done_o) n_done++;
        if (stall && out_valid_o)
          check("hold", 64'({out_data_o, out_kind_o, out_task_o, out_last_o}), h);
        if (out_valid_o && out_ready_i) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_flit actual=%0h required=none", out_data_o);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("flit%0d", n_flit),
                  64'({out_data_o, out_kind_o, out_task_o, out_last_o}), 64'(e));
            n_flit++;
          end
        end
        stall = out_valid_o && !out_ready_i;
        h = 64'({out_data_o, out_kind_o, out_task_o, out_last_o});
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((stim.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(posedge clk_i); n++;
    end
    total++;
    if (stim.size() != 0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain actual=%0d/%0d left required=0", name, stim.size(), exp_q.size());
    end
    repeat (3) @(posedge clk_i);
  endtask

  task automatic check_status(input string name);
    @(negedge clk_i);
    check({name, "_err"}, 64'(err_o), 64'(exp_err));
    check({name, "_apps"}, 64'(n_done), 64'(exp_apps));
  endtask

  task automatic do_reset();
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
    stim.delete(); exp_q.delete();
    exp_err = 1'b0; n_done = 0; exp_apps = 0;
    eoa_i = 1'b1;
    @(negedge clk_i);
    check("rst_outs", 64'({credit_o, out_valid_o, out_data_o, out_kind_o, out_task_o,
                           out_last_o, app_done_o, err_o, done_o}), 64'(0));
    eoa_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("credit_in_reset_cycle", 64'(credit_o), 64'(0));
    @(posedge clk_i); #1;
    check("credit_after_reset", 64'(credit_o), 64'(1));
  endtask

  initial begin
    int n;
    do_reset();

    ready_mode = 1;
    gen_app(2, 1, 1, 8, 4);
    wait_drain("basic", 300);
    check_status("basic");
    check("basic_done_low", 64'(done_o), 64'(0));

    ready_mode = 0;
    gen_app(2, 1, 1, 8, 4);
    repeat (20) @(posedge clk_i);
    @(negedge clk_i);
    check("bp_credit", 64'(credit_o), 64'(0));
    check("bp_head", 64'({out_valid_o, out_data_o, out_kind_o}), 64'({1'b1, 32'd2, 4'd0}));
    check("bp_left", 64'(stim.size()), 64'(11));
    ready_mode = 2;
    wait_drain("bp", 300);
    check_status("bp");

    gen_app(0, 0, 1, 0, 0);
    wait_drain("empty", 100);
    eoa_i = 1'b1;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!done_o && n < 10);
    check("eoa_done", 64'(done_o), 64'(1));
    check_status("empty");
    eoa_i = 1'b0;
    @(posedge clk_i);

    gen_app(1, 1, 1, 2, 1);
    gen_app(0, 1, 1, 6, 2);
    wait_drain("binwords", 300);
    check_status("binwords");

    repeat (8) gen_app($urandom_range(0, 3), $urandom_range(0, 3), 1, -1, -1);
    wait_drain("random", 3000);
    check_status("random");

    gen_app(0, 1, 3, 0, 0);
    wait_drain("badtag", 200);
    check_status("badtag");
    gen_app(1, 2, 1, -1, -1);
    wait_drain("sticky", 300);
    check_status("sticky");

    do_reset();
    gen_app(0, 40, 1, 0, 0);
    wait_drain("clamp", 3000);
    check_status("clamp");

    do_reset();
    ready_mode = 1;
    gen_app(0, 1, 1, 40, 0);
    n = 0;
    while (stim.size() > 6 && n < 200) begin @(posedge clk_i); n++; end
    check("reach_bin", 64'(stim.size() <= 6), 64'(1));
    ready_mode = 0;
    repeat (20) @(posedge clk_i);
    @(negedge clk_i);
    check("bin_full", 64'({credit_o, out_valid_o, out_kind_o}), 64'({1'b0, 1'b1, 4'd9}));
    do_reset();
    ready_mode = 2;
    gen_app(2, 1, 1, 8, 4);
    wait_drain("post_reset", 300);
    check_status("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/app_stream_rx.md
APP_STREAM_RX -- requirements
Module: app_stream_rx

Interface
REQ-001 SHALL have parameter FLIT_SIZE, default 32, meaning stream/output data width in bits.
REQ-002 SHALL have parameter MAX_TASKS, default 32, meaning the largest legal task count per application.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx_i  input  1  upstream flit valid.
REQ-006 SHALL have port data_i  input  FLIT_SIZE  upstream flit.
REQ-007 SHALL have port credit_o  output  1  ready to accept; flit transfers on a rising edge with rx_i=1 and credit_o=1.
REQ-008 SHALL have port eoa_i  input  1  upstream end of all applications, level.
REQ-009 SHALL have port out_valid_o  output  1  output flit valid.
REQ-010 SHALL have port out_ready_i  input  1  downstream ready; output transfers when out_valid_o and out_ready_i are both 1.
REQ-011 SHALL have port out_data_o  output  FLIT_SIZE  flit as received, unmodified.
REQ-012 SHALL have port out_kind_o  output  4  field tag: 0 DSIZE, 1 TCNT, 2 MAP, 3 TAG, 4 GRAPH, 5 TEXT, 6 DATA, 7 BSS, 8 ENTRY, 9 BIN.
REQ-013 SHALL have port out_task_o  output  8  task index (0-based) for MAP/TAG/TEXT..BIN flits, 0 otherwise.
REQ-014 SHALL have port out_last_o  output  1  final flit of the current application.
REQ-015 SHALL have port app_done_o  output  1  one-cycle pulse when the last flit of an application is accepted.
REQ-016 SHALL have port err_o  output  1  sticky protocol error.
REQ-017 SHALL have port done_o  output  1  all applications received and output drained.

Function
REQ-018 Parser FSM states SHALL be DSIZE, TCNT, MAP, TAG, GRAPH, TEXT, DATA, BSS, ENTRY, BIN; each accepted flit advances at most one state.
REQ-019 DSIZE SHALL latch descr_size, go to TCNT; TCNT SHALL latch task_cnt, clear task index, go to MAP if task_cnt>0 else GRAPH.
REQ-020 MAP->TAG each task; TAG SHALL increment task index and go to MAP if index<task_cnt else clear index and go to GRAPH.
REQ-021 TAG flit value other than 1 SHALL set err_o; parsing SHALL continue.
REQ-022 task_cnt > MAX_TASKS SHALL set err_o and be clamped to MAX_TASKS.
REQ-023 GRAPH SHALL consume exactly descr_size flits; descr_size=0 SHALL skip GRAPH entirely.
REQ-024 After GRAPH: go to TEXT if task_cnt>0, else application ends on the TCNT/last GRAPH flit and FSM returns to DSIZE.
REQ-025 TEXT latches text size; DATA latches data size; bin_words = (text+data)>>2, sum computed FLIT_SIZE+1 bits wide, remainder bits discarded.
REQ-026 ENTRY SHALL go to BIN if bin_words>0, else end the task; BIN SHALL consume exactly bin_words flits.
REQ-027 Task end SHALL increment task index, going to TEXT if more tasks remain, else the application ends and FSM returns to DSIZE.
REQ-028 The flit ending an application SHALL be queued with out_last_o=1 and SHALL pulse app_done_o in the cycle after acceptance.
REQ-029 Output SHALL be a 2-entry FIFO holding {data, kind, task, last}; credit_o = (entries < 2), registered-count based, independent of rx_i.
REQ-030 Latency: flit accepted at edge N SHALL be visible on out_*_o after edge N when FIFO was empty; FIFO order preserved.
REQ-031 Simultaneous push and pop SHALL keep entry count unchanged; output held stable while out_valid_o=1 and out_ready_i=0.
REQ-032 rx_i=1 with credit_o=0 SHALL be ignored (no state change).
REQ-033 done_o SHALL be 1 when eoa_i=1, FSM in DSIZE and FIFO empty; eoa_i=1 in any other state SHALL set err_o.

Reset
REQ-034 While rst_ni=1: FSM=DSIZE, counters/latched sizes=0, FIFO empty, out_valid_o=0, out_data_o=0, out_kind_o=0, out_task_o=0, out_last_o=0, app_done_o=0, err_o=0, done_o=0, credit_o=0.
REQ-035 After rst_ni falls, credit_o SHALL be 1 from the first rising edge; reset mid-application SHALL discard all partial state and queued flits.

Verification
REQ-036 App {dsize=2, tcnt=1, map=5, tag=1, graph 7,8, text=8, data=4, bss=0, entry=0x100, 3 bin words}, out_ready_i=1 -> 13 output flits, kinds 0,1,2,3,4,4,5,6,7,8,9,9,9, last only on third BIN, one app_done_o pulse.
REQ-037 Same app with out_ready_i=0 -> credit_o drops after 2 accepts, out_data_o holds first flit; release -> all 13 flits in order, none lost or duplicated.
REQ-038 dsize=0, tcnt=0 -> kinds 0,1 only, last on TCNT flit, FSM back to DSIZE, then eoa_i=1 -> done_o=1 once FIFO drains.
REQ-039 Task with text=2, data=1 -> bin_words=0, ENTRY flit ends task; text=6, data=2 -> exactly 2 BIN flits.
REQ-040 TAG flit=3 -> err_o=1 and stays 1; tcnt=40 -> err_o=1, only 32 MAP/TAG pairs consumed.
REQ-041 Assert rst_ni during BIN with FIFO full -> all outputs at reset values, new app parses correctly from DSIZE.
